// File: rtl/uart_tx_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : Buffered UART transmitter. Bytes from a parallel writer are
//             queued in an internal FIFO and serialised onto tx_port as
//             start / 5..8 data bits (LSB first) / [parity] / stop bit(s).
//             Every bit lasts 16 ticks of the shared 16x oversample strobe.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  FIFO entries (power of two, 2..256)
//    STOP_BITS   stop bits per frame (1 or 2)
//  Ports
//    clk         system clock, rising edge
//    rst_a       asynchronous reset, active-high
//    tick        1-cycle strobe at 16x baud
//    bits        data bits per frame (5..8; other values mean 8)
//    wr_en       write strobe
//    wr_data     byte to queue
//    parity_odd  odd-parity select, latched at frame start (parity build only)
//    tx_port     serial line, idles high
//    busy        a frame is on the line
//    tx_done     1-cycle pulse at the end of the last stop bit
//    full        FIFO holds FIFO_DEPTH entries
//    empty       FIFO holds no entries
//    level       FIFO occupancy
//    overflow    1-cycle pulse when a write is dropped
//  Build option
//    UART_TX_PARITY_EN  adds the parity_odd port and a parity bit per frame
// ============================================================================
module uart_tx_buffered #(
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_a,
  input  logic                          tick,
  input  logic [3:0]                    bits,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx_port,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int              c_AW       = $clog2(FIFO_DEPTH);
  localparam int              c_LW       = c_AW + 1;
  localparam logic [c_LW-1:0] c_DEPTH    = c_LW'(FIFO_DEPTH);
  // Any STOP_BITS value other than 2 behaves as a single stop bit.
  localparam logic            c_TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q;
  logic [c_AW-1:0] rd_ptr_q;
  logic [c_LW-1:0] level_q;
  logic [c_LW-1:0] level_d;
  logic            full_q;
  logic            empty_q;
  logic            overflow_q;

  logic            w_pop;
  logic            w_push;
  logic [7:0]      w_head;

  // A full FIFO still takes a write when the transmitter pops in the same
  // cycle: the slot being read is the one being overwritten, and the read
  // sees the old contents because both happen on the same edge.
  assign w_push = wr_en && (!full_q || w_pop);
  assign w_head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    level_d = level_q;
    if (w_push && !w_pop) begin
      level_d = level_q + c_LW'(1);
    end else if (!w_push && w_pop) begin
      level_d = level_q - c_LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_AW'(1);
      end
      level_q    <= level_d;
      full_q     <= (level_d == c_DEPTH);
      empty_q    <= (level_d == '0);
      overflow_q <= wr_en && !w_push;
    end
  end

  // --------------------------------------------------------------------------
  // Frame serialiser
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;       // tick within the current bit
  logic [2:0] bitcnt_q, bitcnt_d;   // data bit index
  logic       stopcnt_q, stopcnt_d; // stop bit index
  logic [7:0] shift_q, shift_d;
  logic [3:0] nbits_q, nbits_d;     // data bits latched for this frame
  logic       tx_q, tx_d;
  logic       tx_done_q, tx_done_d;

  logic [3:0] w_nbits;
  logic [2:0] w_last_bit;
  logic       w_bit_end;

  assign w_nbits    = ((bits >= 4'd5) && (bits <= 4'd8)) ? bits : 4'd8;
  // nbits is 5..8, so the low three bits minus one give the last index (8 -> 7).
  assign w_last_bit = nbits_q[2:0] - 3'd1;
  assign w_bit_end  = tick && (tcnt_q == 4'hF);

`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
  logic [7:0] w_mask;

  always_comb begin
    w_mask = 8'hFF;
    case (w_nbits)
      4'd5:    w_mask = 8'h1F;
      4'd6:    w_mask = 8'h3F;
      4'd7:    w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    if ((state_q != S_IDLE) && tick) begin
      tcnt_d = tcnt_q + 4'd1;   // wraps to 0 on the 16th tick of a bit
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tick && !empty_q) begin
          w_pop     = 1'b1;
          shift_d   = w_head;
          nbits_d   = w_nbits;
          tx_d      = 1'b0;
          tcnt_d    = 4'd0;
          bitcnt_d  = 3'd0;
          stopcnt_d = 1'b0;
          state_d   = S_START;
`ifdef UART_TX_PARITY_EN
          par_d     = (^(w_head & w_mask)) ^ parity_odd;
`endif
        end
      end

      S_START: begin
        if (w_bit_end) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (bitcnt_q == w_last_bit) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (stopcnt_q == c_TWO_STOP) begin
            tx_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stopcnt_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= S_IDLE;
      tcnt_q    <= 4'd0;
      bitcnt_q  <= 3'd0;
      stopcnt_q <= 1'b0;
      shift_q   <= 8'd0;
      nbits_q   <= 4'd8;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx_port  = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = tx_done_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Self-checking bench for uart_tx_buffered. Frames on tx_port are
//             compared, tick by tick, against a bit list built from the byte,
//             the data-bit count and the stop-bit count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffered;

  localparam int DEPTH = 16;
  localparam int STOPB = 1;

  logic                     clk     = 1'b0;
  logic                     rst_a   = 1'b1;
  logic                     tick    = 1'b0;
  logic [3:0]               bits    = 4'd8;
  logic                     wr_en   = 1'b0;
  logic [7:0]               wr_data = 8'd0;
`ifdef UART_TX_PARITY_EN
  logic                     parity_odd = 1'b0;
`endif
  logic                     tx_port;
  logic                     busy;
  logic                     tx_done;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   tick_div  = 0;   // 0: no ticks, N: one tick every N cycles
  int   tcntr     = 0;
  logic tick_seen = 1'b0; // tick value applied at the most recent rising edge

  logic [7:0] mq[$];     // reference model of the FIFO contents

  uart_tx_buffered #(
    .FIFO_DEPTH (DEPTH),
    .STOP_BITS  (STOPB)
  ) dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .tick       (tick),
    .bits       (bits),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .tx_port    (tx_port),
    .busy       (busy),
    .tx_done    (tx_done),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_seen <= tick;

  // Tick generator: updates 2 time units after each rising edge, after the
  // stimulus tasks (which act 1 unit after the edge) have set tick_div.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tick_div <= 0) begin
        tick  = 1'b0;
        tcntr = 0;
      end else begin
        tick  = (tcntr == 0);
        tcntr = (tcntr + 1 >= tick_div) ? 0 : tcntr + 1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_tick(input int div);
    @(posedge clk);
    #1 tick_div = div;
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Waits for a frame, then follows it tick by tick against the expected bit
  // list. gap = ticks seen on the idle line before the start bit; len = cycles
  // from the start-bit edge to the tx_done edge.
  task automatic expect_frame(input logic [7:0] d, input logic [3:0] rb,
                              output int gap, output int len);
    logic seq[$];
    int   nb, nticks, j, cyc, err_tx, err_busy, err_done, bad_j;
    logic bad_got, bad_want, found, got_done;
`ifdef UART_TX_PARITY_EN
    logic p;
`endif
    nb = ((rb >= 4'd5) && (rb <= 4'd8)) ? int'(rb) : 8;
    seq.delete();
    seq.push_back(1'b0);
    for (int i = 0; i < nb; i++) seq.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    p = parity_odd;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    seq.push_back(p);
`endif
    for (int s = 0; s < STOPB; s++) seq.push_back(1'b1);
    nticks = 16 * seq.size();

    gap = 0; len = 0; found = 1'b0; cyc = 0;
    while (!found && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (tx_port === 1'b0) found = 1'b1;
      else if (tick_seen) gap++;
    end
    n_checks++;
    if (!found || tick_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start data=%h: found=%b on_tick=%b, required 1/1", d, found, tick_seen);
      return;
    end

    j = 0; cyc = 0; err_tx = 0; err_busy = 0; err_done = 0; bad_j = -1;
    bad_got = 1'b0; bad_want = 1'b0; got_done = 1'b0;
    while (1) begin
      if (j == nticks) begin
        got_done = (tx_done === 1'b1) && (tx_port === 1'b1) && (busy === 1'b0);
        break;
      end
      if (tx_port !== seq[j / 16]) begin
        if (err_tx == 0) begin
          bad_j = j; bad_got = tx_port; bad_want = seq[j / 16];
        end
        err_tx++;
      end
      if (busy !== 1'b1)    err_busy++;
      if (tx_done !== 1'b0) err_done++;
      if (cyc >= 40000) break;
      @(negedge clk);
      cyc++;
      if (tick_seen) j++;
    end
    len = cyc;

    n_checks++;
    if (j != nticks) begin
      n_fail++;
      $display("FAIL frame_timeout data=%h: reached tick %0d, required %0d", d, j, nticks);
    end
    n_checks++;
    if (err_tx != 0) begin
      n_fail++;
      $display("FAIL frame_tx data=%h: %0d cycles wrong, first at tick %0d got %b required %b",
               d, err_tx, bad_j, bad_got, bad_want);
    end
    n_checks++;
    if (err_busy != 0) begin
      n_fail++;
      $display("FAIL frame_busy data=%h: busy low in %0d cycles, required 0", d, err_busy);
    end
    n_checks++;
    if (err_done != 0 || !got_done) begin
      n_fail++;
      $display("FAIL frame_done data=%h: early pulses=%0d end_ok=%b, required 0/1", d, err_done, got_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx_port, busy, tx_done, overflow} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_line: tx/busy/done/ovf=%b required 1000", {tx_port, busy, tx_done, overflow});
    end
    n_checks++;
    if ({empty, full} !== 2'b10 || level !== '0) begin
      n_fail++;
      $display("FAIL reset_fifo: empty/full=%b level=%0d required 10/0", {empty, full}, level);
    end
    rst_a = 1'b0;
    set_tick(1);
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (tx_port !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: tx=%b busy=%b empty=%b required 1/0/1", tx_port, busy, empty);
    end
  endtask

  task automatic test_pattern_55();
    int gap, len;
    bits = 4'd8;
    write_byte(8'h55);
    expect_frame(8'h55, 4'd8, gap, len);
    n_checks++;
    if (len != 160) begin
      n_fail++;
      $display("FAIL len_55: %0d cycles required 160", len);
    end
  endtask

  task automatic test_five_bits();
    int gap, len;
    bits = 4'd5;
    write_byte(8'hFF);
    expect_frame(8'hFF, 4'd5, gap, len);
    n_checks++;
    if (len != 112) begin
      n_fail++;
      $display("FAIL len_5bit: %0d ticks required 112", len);
    end
    bits = 4'd8;
  endtask

  task automatic test_random_frames();
    int gap, len, div;
    logic [7:0] d;
    logic [3:0] rb;
    for (int k = 0; k < 6; k++) begin
      div = $urandom_range(1, 3);
      set_tick(div);
      rb   = 4'($urandom_range(0, 15));
      d    = 8'($urandom);
      bits = rb;
      write_byte(d);
      expect_frame(d, rb, gap, len);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    bits = 4'd8;
    set_tick(1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (empty !== 1'b1 || level !== '0) begin
      n_fail++;
      $display("FAIL random_drain: empty=%b level=%0d required 1/0", empty, level);
    end
  endtask

  task automatic test_fill_overflow();
    int gap, len;
    logic [7:0] d, x;
    set_tick(0);
    bits = 4'd8;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      write_byte(d);
      mq.push_back(d);
      n_checks++;
      if (level !== ($clog2(DEPTH)+1)'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_level: %0d required %0d", level, i + 1);
      end
    end
    n_checks++;
    if (full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: full/empty/ovf=%b%b%b required 100", full, empty, overflow);
    end
    write_byte(8'($urandom));   // dropped: FIFO full, no tick so no pop
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_pulse: %b required 1", overflow);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (overflow !== 1'b0 || level !== ($clog2(DEPTH)+1)'(DEPTH) || tx_port !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_overflow: ovf=%b level=%0d tx=%b busy=%b required 0/%0d/1/0",
               overflow, level, tx_port, busy, DEPTH);
    end

    // Write into a full FIFO on the same edge as the first pop.
    x = 8'($urandom);
    @(posedge clk);
    #1;
    wr_en    = 1'b1;
    wr_data  = x;
    tick_div = 1;
    fork
      begin
        @(posedge clk);
        #1 wr_en = 1'b0;
        n_checks++;
        if (level !== ($clog2(DEPTH)+1)'(DEPTH) || full !== 1'b1 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL push_pop_full: level=%0d full=%b ovf=%b required %0d/1/0", level, full, overflow, DEPTH);
        end
      end
      expect_frame(mq[0], 4'd8, gap, len);
    join
    void'(mq.pop_front());
    mq.push_back(x);

    while (mq.size() > 0) begin
      d = mq.pop_front();
      expect_frame(d, 4'd8, gap, len);
      n_checks++;
      if (gap > 1) begin
        n_fail++;
        $display("FAIL back_to_back_gap: %0d idle ticks required <= 1", gap);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== '0) begin
      n_fail++;
      $display("FAIL drained: empty/full=%b%b level=%0d required 10/0", empty, full, level);
    end
  endtask

  task automatic test_slow_tick();
    int gap, len;
    logic [7:0] e;
    set_tick(4);
    bits = 4'd8;
    mq.delete();
    write_byte(8'hA3);
    fork
      expect_frame(8'hA3, 4'd8, gap, len);
      begin
        repeat (150) @(posedge clk);
        #1 bits = 4'($urandom_range(0, 15));
        for (int i = 0; i < 2; i++) begin
          e = 8'($urandom);
          write_byte(e);
          mq.push_back(e);
        end
        n_checks++;
        if (level !== ($clog2(DEPTH)+1)'(2) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL queue_while_busy: level=%0d busy=%b required 2/1", level, busy);
        end
        repeat (100) @(posedge clk);
        #1 bits = 4'd8;
      end
    join
    n_checks++;
    if (len != 640) begin
      n_fail++;
      $display("FAIL len_div4: %0d cycles required 640", len);
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      expect_frame(e, 4'd8, gap, len);
    end
  endtask

  task automatic test_reset_midframe();
    int gap, len, j, cyc, n_done, n_low;
    logic [7:0] d, d2;
    logic found;
    set_tick(1);
    bits = 4'd8;
    d = 8'($urandom);
    write_byte(d);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    found = 1'b0; cyc = 0;
    while (!found && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (tx_port === 1'b0) found = 1'b1;
    end
    j = 0;
    while (j < 72 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (tick_seen) j++;
    end
    n_checks++;
    if (tx_port !== d[3]) begin
      n_fail++;
      $display("FAIL data_bit3: tx=%b required %b", tx_port, d[3]);
    end
    #1 rst_a = 1'b1;
    #1;
    n_checks++;
    if (tx_port !== 1'b1 || busy !== 1'b0 || level !== '0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: tx=%b busy=%b level=%0d empty=%b required 1/0/0/1", tx_port, busy, level, empty);
    end
    @(posedge clk);
    #1 rst_a = 1'b0;
    mq.delete();
    n_done = 0; n_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_done === 1'b1)  n_done++;
      if (tx_port !== 1'b1)  n_low++;
    end
    n_checks++;
    if (n_done != 0 || n_low != 0 || level !== '0) begin
      n_fail++;
      $display("FAIL after_reset_quiet: done=%0d low=%0d level=%0d required 0/0/0", n_done, n_low, level);
    end
    d2 = 8'($urandom);
    write_byte(d2);
    expect_frame(d2, 4'd8, gap, len);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int gap, len;
    set_tick(1);
    bits = 4'd8;
    parity_odd = 1'b0;
    write_byte(8'h07);
    expect_frame(8'h07, 4'd8, gap, len);
    n_checks++;
    if (len != 16 * (10 + STOPB)) begin
      n_fail++;
      $display("FAIL len_parity: %0d required %0d", len, 16 * (10 + STOPB));
    end
    parity_odd = 1'b1;
    write_byte(8'h07);
    expect_frame(8'h07, 4'd8, gap, len);
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pattern_55();
    test_five_bits();
    test_random_frames();
    test_fill_overflow();
    test_slow_tick();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
